// File: rtl/dispatch_buffer_pkg.sv
// Shared micro-op package: machine widths, buffer size and the micro-op payload
// that travels from rename through the dispatch buffer to dispatch.
package dispatch_buffer_pkg;

    // Uops accepted per cycle from rename.
    localparam int unsigned RENAME_WIDTH   = 4;
    // Uops offered per cycle to dispatch.
    localparam int unsigned DISPATCH_WIDTH = 4;
    // Dispatch buffer entries.
    localparam int unsigned DISP_BUF_SIZE  = 16;

    localparam int unsigned OPCODE_W = 8;
    localparam int unsigned REG_W    = 6;
    localparam int unsigned TAG_W    = 16;

    // Renamed micro-op; valid marks an occupied lane.
    typedef struct packed {
        logic                valid;
        logic [OPCODE_W-1:0] opcode;
        logic [REG_W-1:0]    rd;
        logic [TAG_W-1:0]    tag;
    } micro_op_t;

endpackage : dispatch_buffer_pkg

// File: rtl/dispatch_buffer_if.sv
// Rename/dispatch side bundle of the dispatch buffer.
//   uop_in    : renamed group from rename (lane valid = uop_in[i].valid)
//   in_stall  : buffer cannot take a full rename group this cycle
//   uop_out   : oldest entries in program order, lane 0 oldest
//   out_ready : per-lane accept from dispatch (thermometer prefix)
//   count     : current occupancy
// slave is the buffer side, master is the producer/consumer side.
interface dispatch_buffer_if
    import dispatch_buffer_pkg::*;
#(
    parameter int unsigned DEPTH     = DISP_BUF_SIZE,
    parameter int unsigned IN_WIDTH  = RENAME_WIDTH,
    parameter int unsigned OUT_WIDTH = DISPATCH_WIDTH
) ();

    micro_op_t [IN_WIDTH-1:0]  uop_in;
    logic                      in_stall;
    micro_op_t [OUT_WIDTH-1:0] uop_out;
    logic [OUT_WIDTH-1:0]      out_ready;
    logic [$clog2(DEPTH):0]    count;

    modport slave (
        input  uop_in,
        input  out_ready,
        output in_stall,
        output uop_out,
        output count
    );

    modport master (
        output uop_in,
        output out_ready,
        input  in_stall,
        input  uop_out,
        input  count
    );

endinterface : dispatch_buffer_if

// File: rtl/dispatch_buffer.sv
// Dispatch buffer: circular queue between rename and dispatch.
// Accepts a whole rename group per cycle (compacting valid lanes), offers the
// oldest OUT_WIDTH entries to dispatch and pops the accepted thermometer prefix.
// Ports:
//   clock : sole clock, rising edge
//   reset : asynchronous, active-low; clears pointers and occupancy
//   flush : mispredict recover; empties the buffer on the next edge
//   bus   : dispatch_buffer_if.slave (uop_in, in_stall, uop_out, out_ready, count)
module dispatch_buffer
    import dispatch_buffer_pkg::*;
#(
    parameter int unsigned DEPTH     = DISP_BUF_SIZE,
    parameter int unsigned IN_WIDTH  = RENAME_WIDTH,
    parameter int unsigned OUT_WIDTH = DISPATCH_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    dispatch_buffer_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Entry storage is never cleared; occupancy alone decides visibility.
    micro_op_t        mem [DEPTH];

    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;

    logic [CNT_W-1:0] free_slots;
    logic             group_stall;
    logic             push_en;
    logic [CNT_W-1:0] push_n;
    logic [CNT_W-1:0] push_cnt;
    logic [PTR_W-1:0] wr_off [IN_WIDTH];
    logic [OUT_WIDTH-1:0] out_valid;
    logic [CNT_W-1:0] pop_k;
    logic             pop_run;

    // Room check uses the registered occupancy only; pops this cycle give no credit.
    always_comb begin
        free_slots  = CNT_W'(DEPTH) - count_q;
        group_stall = free_slots < CNT_W'(IN_WIDTH);
        bus.in_stall = reset && (flush || group_stall);
        push_en      = reset && !flush && !group_stall;
    end

    // Lane compaction: each valid lane lands at tail + (valid lanes below it).
    always_comb begin
        push_n = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            wr_off[i] = push_n[PTR_W-1:0];
            if (bus.uop_in[i].valid) begin
                push_n = push_n + CNT_W'(1);
            end
        end
        push_cnt = push_en ? push_n : '0;
    end

    // Output lanes show the oldest entries; lanes beyond occupancy read as zero.
    always_comb begin
        bus.uop_out = '0;
        out_valid   = '0;
        for (int i = 0; i < OUT_WIDTH; i++) begin
            out_valid[i] = reset && !flush && (CNT_W'(i) < count_q);
            if (out_valid[i]) begin
                bus.uop_out[i] = mem[head_q + PTR_W'(i)];
            end
        end
    end

    // Pop count: leading run of accepted valid lanes; anything after the first gap is ignored.
    always_comb begin
        pop_k   = '0;
        pop_run = 1'b1;
        for (int i = 0; i < OUT_WIDTH; i++) begin
            if (pop_run && bus.out_ready[i] && out_valid[i]) begin
                pop_k = pop_k + CNT_W'(1);
            end else begin
                pop_run = 1'b0;
            end
        end
    end

    // Pointer and occupancy state; flush and reset both return to empty.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + pop_k[PTR_W-1:0];
            tail_q  <= tail_q + push_cnt[PTR_W-1:0];
            count_q <= count_q + push_cnt - pop_k;
        end
    end

    // Entry writes; only valid lanes of an accepted group are stored.
    always_ff @(posedge clock) begin
        if (push_en) begin
            for (int i = 0; i < IN_WIDTH; i++) begin
                if (bus.uop_in[i].valid) begin
                    mem[tail_q + wr_off[i]] <= bus.uop_in[i];
                end
            end
        end
    end

    assign bus.count = count_q;

endmodule : dispatch_buffer

// File: tb/tb_dispatch_buffer.sv
// Self-checking bench for dispatch_buffer: queue-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dispatch_buffer;
    import dispatch_buffer_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned IW    = 4;
    localparam int unsigned OW    = 4;

    typedef micro_op_t [IW-1:0] grp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;

    always #5 clock = ~clock;

    dispatch_buffer_if #(.DEPTH(DEPTH), .IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

    dispatch_buffer #(.DEPTH(DEPTH), .IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    micro_op_t   model_q[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [15:0] next_tag = 16'd1;

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Valid lanes get sequential tags so program order is visible in the data.
    task automatic make_group(input logic [IW-1:0] vmask, output grp_t g);
        for (int i = 0; i < IW; i++) begin
            g[i].valid  = vmask[i];
            g[i].opcode = 8'($urandom);
            g[i].rd     = 6'($urandom);
            if (vmask[i]) begin
                g[i].tag = next_tag;
                next_tag = next_tag + 16'd1;
            end else begin
                g[i].tag = 16'($urandom);
            end
        end
    endtask

    // One cycle: apply inputs at negedge, compare against the model, advance the model.
    task automatic drive(input logic f, input grp_t g, input logic [OW-1:0] rdy);
        int        sz;
        int        k;
        bit        run;
        bit        exp_stall;
        micro_op_t exp_uop;
        @(negedge clock);
        flush         = f;
        bus.uop_in    = g;
        bus.out_ready = rdy;
        #1;
        sz        = model_q.size();
        exp_stall = f || ((int'(DEPTH) - sz) < int'(IW));
        check_val("in_stall", 64'(bus.in_stall), 64'(exp_stall));
        check_val("count", 64'(bus.count), 64'(sz));
        for (int i = 0; i < OW; i++) begin
            exp_uop = '0;
            if (!f && i < sz) exp_uop = model_q[i];
            check_val($sformatf("uop_out[%0d]", i), 64'(bus.uop_out[i]), 64'(exp_uop));
        end
        if (f) begin
            model_q.delete();
        end else begin
            k   = 0;
            run = 1'b1;
            for (int i = 0; i < OW; i++) begin
                if (run && rdy[i] && i < sz) k++;
                else run = 1'b0;
            end
            repeat (k) void'(model_q.pop_front());
            if (!exp_stall) begin
                for (int i = 0; i < IW; i++) begin
                    if (g[i].valid) model_q.push_back(g[i]);
                end
            end
        end
        cyc++;
    endtask

    // Asynchronous reset between edges; state must clear without a clock.
    task automatic do_reset();
        @(negedge clock);
        #2;
        flush         = 1'b0;
        bus.uop_in    = '0;
        bus.out_ready = '0;
        reset         = 1'b0;
        model_q.delete();
        #1;
        check_val("rst_count", 64'(bus.count), 64'd0);
        check_val("rst_in_stall", 64'(bus.in_stall), 64'd0);
        check_val("rst_uop_out", 64'(bus.uop_out), 64'd0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic after_edge();
        @(posedge clock);
        #1;
    endtask

    grp_t g0;
    grp_t g1;
    grp_t gz;

    initial begin
        flush         = 1'b0;
        bus.uop_in    = '0;
        bus.out_ready = '0;
        gz            = '0;
        #12;
        check_val("init_count", 64'(bus.count), 64'd0);
        check_val("init_in_stall", 64'(bus.in_stall), 64'd0);
        check_val("init_uop_out", 64'(bus.uop_out), 64'd0);
        @(negedge clock);
        reset = 1'b1;

        // Fill to DEPTH with dispatch blocked.
        make_group(4'b1111, g0);
        drive(1'b0, g0, 4'b0000);
        for (int n = 0; n < 3; n++) begin
            make_group(4'b1111, g1);
            drive(1'b0, g1, 4'b0000);
        end
        after_edge();
        check_val("fill_count", 64'(bus.count), 64'd16);
        check_val("fill_in_stall", 64'(bus.in_stall), 64'd1);
        for (int i = 0; i < OW; i++)
            check_val($sformatf("fill_lane%0d", i), 64'(bus.uop_out[i]), 64'(g0[i]));

        // Sparse group is compacted; not visible in the cycle it is written.
        do_reset();
        make_group(4'b1010, g0);
        drive(1'b0, g0, 4'b0000);
        check_val("sparse_no_bypass", 64'(bus.uop_out), 64'd0);
        after_edge();
        check_val("sparse_count", 64'(bus.count), 64'd2);
        check_val("sparse_lane0", 64'(bus.uop_out[0]), 64'(g0[1]));
        check_val("sparse_lane1", 64'(bus.uop_out[1]), 64'(g0[3]));
        check_val("sparse_lane2", 64'(bus.uop_out[2]), 64'd0);
        check_val("sparse_lane3", 64'(bus.uop_out[3]), 64'd0);

        // Count 14: push is refused, three popped.
        do_reset();
        for (int n = 0; n < 3; n++) begin
            make_group(4'b1111, g1);
            drive(1'b0, g1, 4'b0000);
        end
        make_group(4'b0011, g1);
        drive(1'b0, g1, 4'b0000);
        make_group(4'b1111, g1);
        drive(1'b0, g1, 4'b0111);
        check_val("c14_in_stall", 64'(bus.in_stall), 64'd1);
        after_edge();
        check_val("c14_count", 64'(bus.count), 64'd11);

        // Non-thermometer ready: only the leading prefix pops.
        drive(1'b0, gz, 4'b1011);
        after_edge();
        check_val("prefix_count", 64'(bus.count), 64'd9);

        // Steady push/pop across pointer wrap.
        do_reset();
        for (int n = 0; n < 4; n++) begin
            make_group(4'b1111, g1);
            drive(1'b0, g1, 4'b0000);
        end
        drive(1'b0, gz, 4'b1111);
        drive(1'b0, gz, 4'b1111);
        make_group(4'b1111, g1);
        drive(1'b0, g1, 4'b1111);
        for (int n = 0; n < 6; n++) begin
            make_group(4'b1111, g1);
            drive(1'b0, g1, 4'b1111);
        end
        after_edge();
        check_val("wrap_count", 64'(bus.count), 64'd8);

        // Flush with a simultaneous push discards everything.
        do_reset();
        make_group(4'b1111, g1);
        drive(1'b0, g1, 4'b0000);
        make_group(4'b1111, g1);
        drive(1'b0, g1, 4'b0000);
        make_group(4'b0011, g1);
        drive(1'b0, g1, 4'b0000);
        make_group(4'b1111, g1);
        drive(1'b1, g1, 4'b1111);
        check_val("flush_uop_out", 64'(bus.uop_out), 64'd0);
        check_val("flush_in_stall", 64'(bus.in_stall), 64'd1);
        after_edge();
        check_val("flush_count", 64'(bus.count), 64'd0);
        make_group(4'b1111, g1);
        drive(1'b0, g1, 4'b0001);
        make_group(4'b0110, g1);
        drive(1'b0, g1, 4'b0000);
        do_reset();
        drive(1'b0, gz, 4'b1111);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic          f;
            logic [OW-1:0] rdy;
            f = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 1) == 0)
                rdy = OW'((1 << $urandom_range(0, OW)) - 1);
            else
                rdy = OW'($urandom);
            make_group(IW'($urandom), g1);
            drive(f, g1, rdy);
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_dispatch_buffer

// File: doc/dispatch_buffer.md
DISPATCH_BUFFER -- requirements
Module: dispatch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, buffer entries (power of two, >= 2*IN_WIDTH).
REQ-002 SHALL have parameter IN_WIDTH, default `RENAME_WIDTH, uops accepted per cycle from rename.
REQ-003 SHALL have parameter OUT_WIDTH, default `DISPATCH_WIDTH, uops offered per cycle to dispatch.
REQ-004 SHALL use one clock and an asynchronous active-low reset:
  clock  input  1  sole clock, rising edge.
  reset  input  1  asynchronous, active-low; 0 clears all state.
REQ-005 SHALL have these ports:
  flush  input  1  branch-mispredict recover; discards all contents.
  uop_in  input  micro_op_t [IN_WIDTH-1:0]  renamed uops; lane valid = uop_in[i].valid.
  in_stall  output  1  1 = buffer cannot accept a full rename group this cycle.
  uop_out  output  micro_op_t [OUT_WIDTH-1:0]  oldest entries in program order, lane 0 oldest.
  out_ready  input  [OUT_WIDTH-1:0]  per-lane accept from dispatch; must be a thermometer prefix.
  count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-006 SHALL store entries in a circular array with head (oldest) and tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
REQ-007 SHALL assert in_stall combinationally when (DEPTH - count) < IN_WIDTH, using registered count only (no pop credit).
REQ-008 SHALL, when in_stall=0 and flush=0, write all valid uop_in lanes, compacted in lane order, at tail..tail+n-1, where n = number of valid lanes; invalid lanes are skipped, not stored.
REQ-009 SHALL accept a rename group all-or-nothing; when in_stall=1 no lane is written, upstream holds uop_in.
REQ-010 SHALL drive uop_out[i] = entry[head+i] for i < min(count, OUT_WIDTH), and all-zero (valid=0) for remaining lanes.
REQ-011 SHALL pop k entries per cycle, k = number of leading 1s in out_ready restricted to lanes with uop_out[i].valid=1; bits beyond the first 0 are ignored.
REQ-012 SHALL update count_next = count + n - k on the same edge; push and pop in one cycle are both honoured.
REQ-013 SHALL, when flush=1, set head=tail=0 and count=0 on the next edge, ignore uop_in and out_ready that cycle, and drive uop_out all-zero and in_stall=1 combinationally during the flush cycle.
REQ-014 SHALL have zero-cycle bypass disabled: a uop written at edge t appears on uop_out no earlier than the cycle after edge t (latency 1).
REQ-015 SHALL never pop more than count nor write beyond DEPTH; count SHALL stay within 0..DEPTH.
REQ-016 SHALL preserve program order across pointer wrap-around.

Reset
REQ-017 SHALL, while reset=0, asynchronously force head=0, tail=0, count=0; uop_out all-zero and in_stall=0 follow combinationally.
REQ-018 SHALL not require clearing of the entry array; entries beyond count are never visible.
REQ-019 SHALL, on reset assertion mid-operation, discard all contents; the first cycle after deassertion behaves as an empty buffer.

Structure
REQ-020 SHALL take micro_op_t, `RENAME_WIDTH, `DISPATCH_WIDTH from the shared micro-op package; a new `DISP_BUF_SIZE constant (16) SHALL be added there.
REQ-021 SHALL be a single module; the lane-compaction prefix count MAY be a function, no sub-module.
REQ-022 SHALL sit between rat (uop_out -> uop_in; in_stall ORed into rat stall) and dispatch; flush SHALL be driven by the same recover signal as rat.

Verification
REQ-023 Reset then 4 groups of 4 valid uops with out_ready=0 -> count=16, in_stall=1, uop_out lanes 0..OUT_WIDTH-1 = first uops in order.
REQ-024 Group with valid=4'b1010 into empty buffer -> count=2, next cycle uop_out[0]=lane1 uop, uop_out[1]=lane3 uop, uop_out[2..]=0.
REQ-025 count=14, push 4, out_ready=4'b0111 -> in_stall=1 so no push, count=11.
REQ-026 out_ready=4'b1011 with 4 valid outputs -> only 2 popped (prefix rule), count decreases by 2.
REQ-027 count=8 with head=12 (wrapped), push 4 while popping 4 for 6 cycles -> output order matches input order exactly, count stays 8.
REQ-028 flush=1 with count=10 and simultaneous valid push -> uop_out=0 that cycle, count=0 next cycle, pushed group discarded; reset=0 mid-stream -> count=0 immediately, no clock needed.
